alu_ctrl_muldiv: RTL and testbench
==================================

# alu_ctrl_muldiv

Next-generation ALU control for the MIPS datapath: decodes `ALUOp`/funct into the 4-bit ALU operation and `jump_reg` as before, and adds an iterative multiply/divide engine with architectural HI/LO registers. It sits in the EX stage beside the ALU. It raises `stall` to freeze the pipeline whenever an instruction needs a multiply/divide resource that is still busy. Datapath width is parametrised.

## Interface
- `WIDTH`, 32: operand and HI/LO width (≥4, even).
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived).

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `alu_op` in 2: main-control ALU opcode.
- `funct` in 6: instruction funct field.
- `ex_valid` in 1: a real instruction is present in EX.
- `rs_val` in WIDTH: operand A (dividend/multiplicand, mthi/mtlo source).
- `rt_val` in WIDTH: operand B (divisor/multiplier).
- `alu_ctrl` out 4: ALU operation.
- `jump_reg` out 1: jr detected.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: engine is iterating.
- `stall` out 1: hold IF/ID/EX this cycle.

## Operation
- Decode is combinational. Every input combination drives every output, so no latches are inferred.
- `alu_op`=0 → 2 (add); 1 → 6 (sub); 3 → 0 (and).
- `alu_op`=2, decoded by funct:
  - 36→0, 37→1, 32→2, 34→6, 42→7, 39→12, 0→13 (sll), 2→14 (srl).
  - Any other funct → 3 (invalid/nop).
- `jump_reg` = (`alu_op`==2 && funct==8). It is 0 otherwise.
- Muldiv funct codes (only when `alu_op`==2): 24 mult, 25 multu, 26 div, 27 divu, 16 mfhi, 17 mthi, 18 mflo, 19 mtlo.
- FSM states:
  - IDLE: accepts muldiv and mthi/mtlo.
  - RUN: one shift-add or restoring-subtract step per cycle, WIDTH steps total.
  - FIX: sign correction and HI/LO writeback, then back to IDLE.
- Start condition: `ex_valid` && state==IDLE && funct∈{24..27}. On start, latch the magnitudes of the operands (signed ops) and their signs, clear the counter, and go to RUN.
- Product mapping: HI = upper WIDTH bits, LO = lower WIDTH bits.
- Quotient/remainder mapping: LO = quotient, HI = remainder.
- Signed division: quotient sign = sign(A)^sign(B); remainder sign = sign(A).
- Divide by zero: no trap. LO = all ones, HI = A (raw). The operation takes the full latency.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- mthi/mtlo in IDLE: write `rs_val` into HI/LO at the next edge.
- `stall` = `ex_valid` && (state≠IDLE) && funct∈{16..19, 24..27} && `alu_op`==2.
  - A muldiv, mthi/mtlo or mfhi/mflo arriving while busy is held, not dropped.
  - Non-muldiv instructions never stall.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `stall`=0, counter 0.
  - `alu_ctrl` and `jump_reg` follow the inputs combinationally.
- `busy`=1 in RUN and FIX.
- Latency: the start edge is at cycle 0. RUN lasts cycles 1..WIDTH. FIX is cycle WIDTH+1. New HI/LO are visible from cycle WIDTH+2, which is 34 cycles for WIDTH=32.
- A muldiv held by `stall` starts on the first cycle the FSM is back in IDLE. Back-to-back operations therefore have a WIDTH+2 cycle cadence.
- HI/LO change only at the FIX edge, or at an mthi/mtlo edge in IDLE. Intermediate values are never exposed.
- Reset in RUN or FIX aborts the operation: state returns to IDLE and HI/LO are cleared on that same edge.
- If `ex_valid` is low at the start edge, nothing happens.

## Configuration
- `ALU_CTRL_DIV_EN`:
  - Defined: div/divu are implemented as above.
  - Undefined: the divider datapath is removed. funct 26/27 decode to `alu_ctrl`=3, never start the FSM, never stall, and leave HI/LO unchanged. Multiply behaviour is unaffected.

## Structure
- The shared package `mips_pkg` holds:
  - ALU control constants: AND, OR, ADD, SUB, SLT, NOR, SLL, SRL, INVALID.
  - Funct codes: FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_JR.
  - ALUOp codes.
  - The FSM state enum.
- One sub-module, `muldiv_iter`. It holds the WIDTH-parametrised iterative core: FSM, counter, accumulator/remainder, sign fix. The top level holds the decode and stall logic.

## Test plan
- Reset mid-RUN (mult 7×9, reset at cycle 5) → `busy`=0, `hi`=`lo`=0 next cycle. A following idle cycle shows no writeback.
- mult A=−3, B=5 (WIDTH=32) → after 34 cycles `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. `busy` is high for exactly cycles 1..33.
- div A=−7, B=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu 7/0 → `lo`=0xFFFFFFFF, `hi`=7.
- mflo issued the cycle after a multu start → `stall` high for 33 cycles. It releases when `busy` falls, and `lo` then holds the new product.
- `alu_op`=2 sweep: funct 36/37/32/34/42/39/0/2/8/63 → `alu_ctrl` 0/1/2/6/7/12/13/14/3/3. `jump_reg`=1 only for 8. `alu_op`=0/1/3 → 2/6/0.
- Build without `ALU_CTRL_DIV_EN`: div 10/3 → `stall`=0, `busy`=0, HI/LO unchanged, `alu_ctrl`=3.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS EX-stage control blocks.
//   - 4-bit ALU operation codes driven to the ALU
//   - R-type funct codes (ALU ops, jr, multiply/divide and HI/LO moves)
//   - 2-bit main-control ALUOp codes
//   - state encoding of the iterative multiply/divide engine
package mips_pkg;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_INVALID = 4'd3;
  localparam logic [3:0] ALU_SUB     = 4'd6;
  localparam logic [3:0] ALU_SLT     = 4'd7;
  localparam logic [3:0] ALU_NOR     = 4'd12;
  localparam logic [3:0] ALU_SLL     = 4'd13;
  localparam logic [3:0] ALU_SRL     = 4'd14;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE = 2'd2;
  localparam logic [1:0] ALUOP_AND   = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide core with architectural HI/LO.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// WIDTH steps, then a single sign-fix/writeback cycle.
// Optional feature macro: ALU_CTRL_DIV_EN (divider datapath present).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request a mult/multu/div/divu (taken only when idle)
//   op_signed       signed variant (mult/div)
//   op_div          divide rather than multiply
//   wr_hi, wr_lo    mthi/mtlo write strobes (honoured only when idle)
//   a, b            operand A (also mthi/mtlo data) and operand B
//   hi, lo          architectural HI/LO
//   busy            engine in RUN or FIX
module muldiv_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic             op_div,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  // acc_hi: product upper half / partial remainder
  // acc_lo: multiplier being shifted out / quotient being shifted in
  // opnd  : multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_q;
  logic             go;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign mag_a = (op_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b = (op_signed && b[WIDTH-1]) ? -b : b;

  assign add_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef ALU_CTRL_DIV_EN
  logic             is_div, neg_r, div0, sub_ok;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff, rem_nxt, q_fix, r_fix;

  assign go      = start;
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign sub_ok  = shifted >= {1'b0, opnd};
  // The true difference is below the divisor, so modulo-2^WIDTH is exact.
  assign diff    = shifted[WIDTH-1:0] - opnd;
  assign rem_nxt = sub_ok ? diff : shifted[WIDTH-1:0];
  // With a zero divisor every step subtracts 0, leaving |A| as the remainder;
  // re-applying A's sign restores raw A in HI. Only LO needs overriding.
  assign q_fix   = div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
  assign r_fix   = neg_r ? -acc_hi : acc_hi;
`else
  // No divider: div/divu requests are ignored outright.
  assign go = start && !op_div;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            // Multiply is commutative, so both ops share one load pattern.
            acc_hi <= '0;
            acc_lo <= mag_a;
            opnd   <= mag_b;
            neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_CTRL_DIV_EN
            is_div <= op_div;
            neg_r  <= op_signed && a[WIDTH-1];
            div0   <= (b == '0);
`endif
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
          end
        end
        ST_RUN: begin
`ifdef ALU_CTRL_DIV_EN
          if (is_div) begin
            acc_hi <= rem_nxt;
            acc_lo <= {acc_lo[WIDTH-2:0], sub_ok};
          end else
`endif
          {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
`ifdef ALU_CTRL_DIV_EN
          if (is_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else
`endif
          begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: EX-stage ALU control with iterative multiply/divide.
// Decodes ALUOp/funct to the 4-bit ALU operation and jr, drives the
// muldiv_iter core, and stalls the pipeline when a muldiv-class instruction
// meets a busy engine.
// Optional feature macro: ALU_CTRL_DIV_EN (div/divu supported when defined).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   alu_op, funct   main-control ALUOp and instruction funct field
//   ex_valid        real instruction in EX
//   rs_val, rt_val  operands A and B
//   alu_ctrl        ALU operation (combinational)
//   jump_reg        jr detected (combinational)
//   hi, lo          architectural HI/LO
//   busy            engine iterating (RUN or FIX)
//   stall           hold IF/ID/EX this cycle
module alu_ctrl_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_ctrl,
  output logic             jump_reg,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  logic rtype, is_mul, is_div, is_mvhl, vld_rt;

  assign rtype   = (alu_op == ALUOP_RTYPE);
  assign vld_rt  = ex_valid && rtype;
  assign is_mul  = (funct == FN_MULT) || (funct == FN_MULTU);
`ifdef ALU_CTRL_DIV_EN
  assign is_div  = (funct == FN_DIV) || (funct == FN_DIVU);
`else
  assign is_div  = 1'b0;
`endif
  assign is_mvhl = (funct >= FN_MFHI) && (funct <= FN_MTLO);

  assign jump_reg = rtype && (funct == FN_JR);
  // busy mirrors state!=IDLE, so this holds any HI/LO consumer or producer.
  assign stall    = vld_rt && busy && (is_mul || is_div || is_mvhl);

  always_comb begin
    alu_ctrl = ALU_INVALID;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_AND: alu_ctrl = ALU_AND;
      default: begin
        case (funct)
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          default: alu_ctrl = ALU_INVALID;
        endcase
      end
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_md (
    .clk       (clk),
    .reset     (reset),
    .start     (vld_rt && (is_mul || is_div)),
    .op_signed ((funct == FN_MULT) || (funct == FN_DIV)),
    .op_div    ((funct == FN_DIV) || (funct == FN_DIVU)),
    .wr_hi     (vld_rt && (funct == FN_MTHI)),
    .wr_lo     (vld_rt && (funct == FN_MTLO)),
    .a         (rs_val),
    .b         (rt_val),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv (WIDTH=32). Expected HI/LO come from
// plain 64-bit / signed integer arithmetic; divide results depend on whether
// ALU_CTRL_DIV_EN is defined for the build.
module tb_alu_ctrl_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic         ex_valid;
  logic [W-1:0] rs_val, rt_val;
  logic [3:0]   alu_ctrl;
  logic         jump_reg, busy, stall;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  alu_ctrl_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct),
    .ex_valid(ex_valid), .rs_val(rs_val), .rt_val(rt_val),
    .alu_ctrl(alu_ctrl), .jump_reg(jump_reg), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit engine_op(input logic [5:0] fn);
`ifdef ALU_CTRL_DIV_EN
    return fn >= 6'd24 && fn <= 6'd27;
`else
    return fn == 6'd24 || fn == 6'd25;
`endif
  endfunction

  // Architectural effect of one instruction on HI/LO.
  task automatic model_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [63:0] pu;
    int sa, sb;
    sa = a;
    sb = b;
    case (fn)
      6'd24: begin p = longint'(sa) * longint'(sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      6'd25: begin pu = {32'b0, a} * {32'b0, b}; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
`ifdef ALU_CTRL_DIV_EN
      6'd26: begin
        if (b == 0) begin exp_lo = '1; exp_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin exp_lo = a; exp_hi = 0; end
        else begin exp_lo = sa / sb; exp_hi = sa % sb; end
      end
      6'd27: begin
        if (b == 0) begin exp_lo = '1; exp_hi = a; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
`endif
      6'd17: exp_hi = a;
      6'd19: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one instruction from idle, then wait for the engine and check.
  task automatic do_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    logic [W-1:0] h0, l0;
    int n;
    bit early;
    h0 = exp_hi;
    l0 = exp_lo;
    ex_valid = 1'b1; alu_op = 2'd2; funct = fn; rs_val = a; rt_val = b;
    #1;
    chk({tag, " idle_stall"}, stall, 0);
    step();
    ex_valid = 1'b0; alu_op = 2'd0; funct = 6'd0;
    rs_val = $urandom; rt_val = $urandom;
    model_op(fn, a, b);
    n = 0;
    early = 0;
    while (busy && n < 100) begin
      if (hi !== h0 || lo !== l0) early = 1;
      n++;
      step();
    end
    chk({tag, " busy_cycles"}, n, engine_op(fn) ? W + 1 : 0);
    chk({tag, " no_early_hilo"}, early, 0);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int fn_l[10]  = '{36, 37, 32, 34, 42, 39, 0, 2, 8, 63};
    int exp_l[10] = '{0, 1, 2, 6, 7, 12, 13, 14, 3, 3};
    int op_l[6]   = '{24, 25, 26, 27, 17, 19};
    int n;
    logic [5:0] fn;

    reset = 1'b1; ex_valid = 1'b0; alu_op = 2'd0; funct = 6'd0;
    rs_val = '0; rt_val = '0;
    step(); step();
    reset = 1'b0;
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst busy", busy, 0);
    chk("rst stall", stall, 0);

    // Decode sweep
    alu_op = 2'd2;
    for (int i = 0; i < 10; i++) begin
      funct = 6'(fn_l[i]);
      #1;
      chk($sformatf("dec fn%0d", fn_l[i]), alu_ctrl, exp_l[i]);
      chk($sformatf("jr fn%0d", fn_l[i]), jump_reg, fn_l[i] == 8);
    end
    funct = 6'd26;
    #1;
    chk("dec div", alu_ctrl, 3);
    funct = 6'd8;
    alu_op = 2'd0; #1; chk("dec op0", alu_ctrl, 2); chk("jr op0", jump_reg, 0);
    alu_op = 2'd1; #1; chk("dec op1", alu_ctrl, 6);
    alu_op = 2'd3; #1; chk("dec op3", alu_ctrl, 0);
    alu_op = 2'd0; funct = 6'd0;
    step();

    // Directed ops
    do_op(6'd24, -32'sd3, 32'd5, "mult_m3x5");
    chk("mult_m3x5 hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_m3x5 lo_const", lo, 32'hFFFF_FFF1);
    do_op(6'd26, -32'sd7, 32'd2, "div_m7d2");
    do_op(6'd27, 32'd7, 32'd0, "divu_7d0");
    do_op(6'd26, 32'd10, 32'd3, "div_10d3");
    do_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(6'd26, -32'sd9, 32'd0, "div_m9d0");
    do_op(6'd17, 32'h1234_5678, 32'd0, "mthi");
    do_op(6'd19, 32'h9ABC_DEF0, 32'd0, "mtlo");

    // Random ops
    for (int i = 0; i < 16; i++) begin
      fn = 6'(op_l[$urandom_range(0, 5)]);
      do_op(fn, pick(), pick(), $sformatf("rnd%0d_fn%0d", i, fn));
    end

    // mflo the cycle after a multu start: held until the engine is idle
    ex_valid = 1'b1; alu_op = 2'd2; funct = 6'd25;
    rs_val = 32'hDEAD_BEEF; rt_val = 32'h0000_1003;
    step();
    model_op(6'd25, 32'hDEAD_BEEF, 32'h0000_1003);
    funct = 6'd18;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; step(); end
    chk("mflo stall_cycles", n, W + 1);
    chk("mflo busy_after", busy, 0);
    chk("mflo lo", lo, exp_lo);
    chk("mflo hi", hi, exp_hi);
    ex_valid = 1'b0; funct = 6'd0;
    step();

    // Back-to-back: second mult held by stall, starts once idle
    ex_valid = 1'b1; alu_op = 2'd2; funct = 6'd25;
    rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    step();
    model_op(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    funct = 6'd24; rs_val = 32'h7FFF_FFFF; rt_val = 32'h8000_0000;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; step(); end
    chk("b2b stall_cycles", n, W + 1);
    chk("b2b first hi", hi, exp_hi);
    chk("b2b first lo", lo, exp_lo);
    step();
    ex_valid = 1'b0; funct = 6'd0;
    model_op(6'd24, 32'h7FFF_FFFF, 32'h8000_0000);
    n = 0;
    while (busy && n < 100) begin n++; step(); end
    chk("b2b second busy_cycles", n, W + 1);
    chk("b2b second hi", hi, exp_hi);
    chk("b2b second lo", lo, exp_lo);

    // Reset mid-RUN aborts the op and clears HI/LO on the same edge
    do_op(6'd17, 32'hA5A5_A5A5, 32'd0, "pre_rst_mthi");
    ex_valid = 1'b1; alu_op = 2'd2; funct = 6'd24; rs_val = 32'd7; rt_val = 32'd9;
    step();
    funct = 6'd32;
    #1;
    chk("busy add no_stall", stall, 0);
    chk("busy add alu_ctrl", alu_ctrl, 2);
    ex_valid = 1'b0; funct = 6'd0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_run busy", busy, 0);
    chk("rst_run hi", hi, 0);
    chk("rst_run lo", lo, 0);
    step();
    chk("post_rst busy", busy, 0);
    chk("post_rst hi", hi, 0);
    chk("post_rst lo", lo, 0);
    exp_hi = '0; exp_lo = '0;
    do_op(6'd24, 32'd7, 32'd9, "mult_7x9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
